// File: rtl/idecode_ucode_pkg.sv
// Shared decode definitions: opcodes, field positions, state and micro-op encodings.
package idecode_ucode_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned OPC_W     = 7;
  localparam int unsigned REG_W     = 4;
  localparam int unsigned IMM_W     = 16;
  localparam int unsigned STEP_W    = 5;
  localparam int unsigned MUL_STEPS = 16;

  // Instruction field bit positions, shared with fetch and execute.
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 25;
  localparam int unsigned RD_MSB  = 24;
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RS1_MSB = 20;
  localparam int unsigned RS1_LSB = 17;
  localparam int unsigned RS2_MSB = 15;
  localparam int unsigned RS2_LSB = 12;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OPC_W-1:0] OP_MUL = 7'b0001100;
  localparam logic [OPC_W-1:0] OP_B   = 7'b1100000;
  localparam logic [OPC_W-1:0] OP_NOP = 7'b1100100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_UCLR  = 3'd2,
    S_USTEP = 3'd3,
    S_UWB   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    UOP_CLR  = 2'd0,
    UOP_STEP = 2'd1,
    UOP_WB   = 2'd2
  } uop_kind_t;

  // Registered decode payload presented to execute.
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic             reg_write;
    logic             valid;
  } dec_t;

  // Sign-extend a 16-bit immediate to the datapath width.
  function automatic logic [XLEN-1:0] sext16(input logic [IMM_W-1:0] v);
    return {{(XLEN-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  // Opcodes whose plain decode writes rd; MUL writes only from its WB micro-op.
  function automatic logic writes_rd(input logic [OPC_W-1:0] op);
    return !((op == OP_B) || (op == OP_NOP) || (op == OP_MUL));
  endfunction

  // Bubble payload used when a held instruction is squashed.
  function automatic dec_t nop_dec();
    dec_t d;
    d        = '0;
    d.opcode = OP_NOP;
    return d;
  endfunction

endpackage

// File: rtl/idecode_ucode_mul_useq.sv
// MUL micro-op sequencer: CLR, MUL_STEPS x STEP, WB, with abort on execute redirect.
module idecode_ucode_mul_useq
  import idecode_ucode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              wb_o,
  output logic              release_o,
  output uop_kind_t         kind_o,
  output logic [STEP_W-1:0] step_o
);

  state_t            phase_q;
  logic [STEP_W-1:0] step_q;

  // Micro-sequence phase and step counter; any abort drops straight back to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= S_IDLE;
      step_q  <= '0;
    end else begin
      case (phase_q)
        S_IDLE: begin
          step_q <= '0;
          if (start_i) phase_q <= S_UCLR;
        end
        S_UCLR: begin
          step_q  <= '0;
          phase_q <= abort_i ? S_IDLE : S_USTEP;
        end
        S_USTEP: begin
          if (abort_i) begin
            phase_q <= S_IDLE;
            step_q  <= '0;
          end else if (step_q == STEP_W'(MUL_STEPS - 1)) begin
            phase_q <= S_UWB;
            step_q  <= '0;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        S_UWB: begin
          phase_q <= S_IDLE;
          step_q  <= '0;
        end
        default: begin
          phase_q <= S_IDLE;
          step_q  <= '0;
        end
      endcase
    end
  end

  // Micro-op kind decoded from the current phase.
  always_comb begin
    kind_o = UOP_CLR;
    case (phase_q)
      S_USTEP: kind_o = UOP_STEP;
      S_UWB:   kind_o = UOP_WB;
      default: kind_o = UOP_CLR;
    endcase
  end

  assign busy_o    = (phase_q != S_IDLE);
  assign wb_o      = (phase_q == S_UWB);
  assign release_o = wb_o || (busy_o && abort_i);
  assign step_o    = step_q;

endmodule

// File: rtl/idecode_ucode.sv
// Decode stage: registers fetched words, splits fields, expands MUL into micro-ops.
module idecode_ucode
  import idecode_ucode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   instrIn,
  input  logic [XLEN-1:0]   pcIn,
  input  logic              exeOverride,
  output logic [OPC_W-1:0]  opcode,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  rs1,
  output logic [REG_W-1:0]  rs2,
  output logic [XLEN-1:0]   imm32,
  output logic [XLEN-1:0]   pcOut,
  output logic              regWrite,
  output logic              decValid,
  output logic              uopValid,
  output logic [1:0]        uopKind,
  output logic [STEP_W-1:0] uopStep,
  output logic              mul_trigger,
  output logic              mul_release
);

  state_t            state_q;
  dec_t              dec_q;
  dec_t              cap_c;
  logic              useq_busy;
  logic              useq_wb;
  logic              useq_rel;
  logic              held_mul;
  logic              trig_c;
  logic              abort_c;
  logic              unused_bits;
  uop_kind_t         useq_kind;
  logic [STEP_W-1:0] useq_step;

  // Split the incoming word into its raw fields.
  always_comb begin
    cap_c           = '0;
    cap_c.opcode    = instrIn[OPC_MSB:OPC_LSB];
    cap_c.rd        = instrIn[RD_MSB:RD_LSB];
    cap_c.rs1       = instrIn[RS1_MSB:RS1_LSB];
    cap_c.rs2       = instrIn[RS2_MSB:RS2_LSB];
    cap_c.imm       = sext16(instrIn[IMM_MSB:IMM_LSB]);
    cap_c.pc        = pcIn;
    cap_c.reg_write = writes_rd(instrIn[OPC_MSB:OPC_LSB]);
    cap_c.valid     = 1'b1;
  end

  // Bit 16 is a spare position in every format.
  assign unused_bits = instrIn[16];

  assign held_mul = (state_q == S_RUN) && !useq_busy && dec_q.valid &&
                    (dec_q.opcode == OP_MUL);
  assign trig_c   = held_mul && !exeOverride && !rst;
  assign abort_c  = useq_busy && exeOverride;

  idecode_ucode_mul_useq u_useq (
    .clk       (clk),
    .rst       (rst),
    .start_i   (trig_c),
    .abort_i   (exeOverride),
    .busy_o    (useq_busy),
    .wb_o      (useq_wb),
    .release_o (useq_rel),
    .kind_o    (useq_kind),
    .step_o    (useq_step)
  );

  // Top decode FSM: capture each cycle, freeze during MUL, squash on redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dec_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_RUN;
        S_RUN: begin
          if (exeOverride) begin
            dec_q <= nop_dec();
          end else if (useq_busy) begin
            // Fetch resumes as the WB micro-op retires.
            if (useq_wb) dec_q <= cap_c;
          end else if (!held_mul) begin
            dec_q <= cap_c;
          end
        end
        default: begin
          state_q <= S_IDLE;
          dec_q   <= '0;
        end
      endcase
    end
  end

  assign opcode      = dec_q.opcode;
  assign rd          = dec_q.rd;
  assign rs1         = dec_q.rs1;
  assign rs2         = dec_q.rs2;
  assign imm32       = dec_q.imm;
  assign pcOut       = dec_q.pc;
  assign decValid    = dec_q.valid;
  assign regWrite    = (dec_q.reg_write || useq_wb) && !abort_c;
  assign uopValid    = useq_busy;
  assign uopKind     = useq_kind;
  assign uopStep     = useq_step;
  assign mul_trigger = trig_c;
  assign mul_release = useq_rel && !rst;

endmodule

// File: tb/tb_idecode_ucode.sv
// Directed bench for idecode_ucode with immediate-assertion checks.
module tb_idecode_ucode;

  localparam logic [6:0] T_MUL = 7'b0001100;
  localparam logic [6:0] T_B   = 7'b1100000;
  localparam logic [6:0] T_NOP = 7'b1100100;
  localparam logic [6:0] T_ADD = 7'b0000001;
  localparam logic [6:0] T_SUB = 7'b0000010;

  logic        clk;
  logic        rst;
  logic [31:0] instrIn;
  logic [31:0] pcIn;
  logic        exeOverride;
  logic [6:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [31:0] imm32;
  logic [31:0] pcOut;
  logic        regWrite;
  logic        decValid;
  logic        uopValid;
  logic [1:0]  uopKind;
  logic [4:0]  uopStep;
  logic        mul_trigger;
  logic        mul_release;

  int n_checks = 0;
  int n_errors = 0;
  int trig_cnt = 0;
  int rel_cnt  = 0;

  idecode_ucode dut (
    .clk         (clk),
    .rst         (rst),
    .instrIn     (instrIn),
    .pcIn        (pcIn),
    .exeOverride (exeOverride),
    .opcode      (opcode),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .imm32       (imm32),
    .pcOut       (pcOut),
    .regWrite    (regWrite),
    .decValid    (decValid),
    .uopValid    (uopValid),
    .uopKind     (uopKind),
    .uopStep     (uopStep),
    .mul_trigger (mul_trigger),
    .mul_release (mul_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [3:0] rdv,
                                     input logic [3:0] rs1v, input logic [15:0] imm);
    return {op, rdv, rs1v, 1'b0, imm};
  endfunction

  // MUL word must already be on instrIn; follows it from trigger to release.
  task automatic run_mul(input logic [3:0] rdv, input logic [31:0] follow);
    int len;
    tick();
    chk("trig_pulse", mul_trigger, 1);
    chk("trig_norel", mul_release, 0);
    chk("trig_opcode", opcode, T_MUL);
    chk("trig_rd", rd, rdv);
    chk("trig_uopv", uopValid, 0);
    chk("trig_rw", regWrite, 0);
    if (mul_trigger === 1'b1) trig_cnt++;
    instrIn = follow;
    len = 1;
    while (mul_release !== 1'b1 && len < 40) begin
      tick();
      len++;
      if (mul_trigger === 1'b1) trig_cnt++;
      if (mul_release === 1'b1) rel_cnt++;
      chk("seq_notrig", mul_trigger, 0);
      if (len == 2) begin
        chk("clr_uopv", uopValid, 1);
        chk("clr_kind", uopKind, 0);
      end else if (len <= 18) begin
        chk("step_kind", uopKind, 1);
        chk("step_idx", uopStep, len - 3);
        chk("step_rw", regWrite, 0);
      end else begin
        chk("wb_kind", uopKind, 2);
        chk("wb_rw", regWrite, 1);
        chk("wb_rd", rd, rdv);
      end
    end
    chk("mul_len", len, 19);
  endtask

  initial begin
    rst = 1'b1;
    instrIn = '0;
    pcIn = '0;
    exeOverride = 1'b0;

    // Reset held three cycles.
    repeat (3) tick();
    chk("rst_opcode", opcode, 0);
    chk("rst_rd", rd, 0);
    chk("rst_rs1", rs1, 0);
    chk("rst_rs2", rs2, 0);
    chk("rst_imm", imm32, 0);
    chk("rst_pc", pcOut, 0);
    chk("rst_rw", regWrite, 0);
    chk("rst_valid", decValid, 0);
    chk("rst_uopv", uopValid, 0);
    chk("rst_kind", uopKind, 0);
    chk("rst_step", uopStep, 0);
    chk("rst_trig", mul_trigger, 0);
    chk("rst_rel", mul_release, 0);

    // ADD rd=3 rs1=1, imm 0xFFF0 (rs2 overlaps imm[15:12] = 0xF).
    rst = 1'b0;
    instrIn = mk(T_ADD, 4'd3, 4'd1, 16'hFFF0);
    pcIn = 32'h0000_0100;
    tick();
    chk("idle_valid", decValid, 0);
    tick();
    chk("add_valid", decValid, 1);
    chk("add_opcode", opcode, T_ADD);
    chk("add_rd", rd, 3);
    chk("add_rs1", rs1, 1);
    chk("add_rs2", rs2, 4'hF);
    chk("add_imm", imm32, 32'hFFFF_FFF0);
    chk("add_rw", regWrite, 1);
    chk("add_pc", pcOut, 32'h0000_0100);
    chk("add_uopv", uopValid, 0);

    // R-type with rs2=2 and a positive immediate.
    instrIn = mk(T_SUB, 4'd9, 4'd4, 16'h2345);
    pcIn = 32'h0000_0104;
    tick();
    chk("sub_rd", rd, 9);
    chk("sub_rs1", rs1, 4);
    chk("sub_rs2", rs2, 2);
    chk("sub_imm", imm32, 32'h0000_2345);
    chk("sub_rw", regWrite, 1);

    // Branch held, then squashed by a redirect.
    instrIn = mk(T_B, 4'd0, 4'd0, 16'h0010);
    pcIn = 32'h0000_0108;
    tick();
    chk("b_opcode", opcode, T_B);
    chk("b_rw", regWrite, 0);
    chk("b_valid", decValid, 1);
    exeOverride = 1'b1;
    instrIn = mk(T_ADD, 4'd3, 4'd1, 16'h0001);
    tick();
    chk("sq_opcode", opcode, T_NOP);
    chk("sq_valid", decValid, 0);
    chk("sq_rw", regWrite, 0);
    exeOverride = 1'b0;
    tick();
    chk("post_sq_valid", decValid, 1);
    chk("post_sq_opcode", opcode, T_ADD);

    // Held MUL squashed in its own cycle: no trigger, no sequence.
    instrIn = mk(T_MUL, 4'd5, 4'd2, 16'h3000);
    tick();
    instrIn = mk(T_ADD, 4'd1, 4'd1, 16'h0001);
    exeOverride = 1'b1;
    #1;
    chk("sqmul_notrig", mul_trigger, 0);
    tick();
    chk("sqmul_uopv", uopValid, 0);
    chk("sqmul_opcode", opcode, T_NOP);
    exeOverride = 1'b0;

    // Full MUL rd=5.
    instrIn = mk(T_MUL, 4'd5, 4'd2, 16'h3000);
    run_mul(4'd5, mk(T_ADD, 4'd1, 4'd1, 16'h0001));
    tick();
    chk("after_mul_rel", mul_release, 0);
    chk("after_mul_uopv", uopValid, 0);
    chk("after_mul_opcode", opcode, T_ADD);
    chk("after_mul_valid", decValid, 1);

    // Abort at STEP 7.
    instrIn = mk(T_MUL, 4'd8, 4'd2, 16'h3000);
    tick();
    chk("ab_trig", mul_trigger, 1);
    instrIn = mk(T_ADD, 4'd2, 4'd2, 16'h0002);
    tick();
    repeat (8) tick();
    chk("ab_step7", uopStep, 7);
    chk("ab_kind", uopKind, 1);
    exeOverride = 1'b1;
    #1;
    chk("ab_rel", mul_release, 1);
    chk("ab_rw", regWrite, 0);
    tick();
    chk("ab_rel_once", mul_release, 0);
    chk("ab_uopv", uopValid, 0);
    chk("ab_opcode", opcode, T_NOP);
    chk("ab_valid", decValid, 0);
    exeOverride = 1'b0;
    tick();
    chk("ab_resume", opcode, T_ADD);

    // Next MUL after an abort still runs the full sequence.
    instrIn = mk(T_MUL, 4'd4, 4'd2, 16'h3000);
    run_mul(4'd4, mk(T_ADD, 4'd1, 4'd1, 16'h0001));

    // Redirect coinciding with WB: abort wins, single release.
    instrIn = mk(T_MUL, 4'd10, 4'd2, 16'h3000);
    tick();
    chk("wbab_trig", mul_trigger, 1);
    instrIn = mk(T_ADD, 4'd2, 4'd2, 16'h0002);
    repeat (18) tick();
    chk("wbab_kind", uopKind, 2);
    chk("wbab_rw_pre", regWrite, 1);
    exeOverride = 1'b1;
    #1;
    chk("wbab_rw", regWrite, 0);
    chk("wbab_rel", mul_release, 1);
    tick();
    chk("wbab_rel_once", mul_release, 0);
    chk("wbab_opcode", opcode, T_NOP);
    chk("wbab_uopv", uopValid, 0);
    exeOverride = 1'b0;

    // Back-to-back MULs.
    trig_cnt = 0;
    rel_cnt = 0;
    instrIn = mk(T_MUL, 4'd6, 4'd2, 16'h3000);
    run_mul(4'd6, mk(T_MUL, 4'd7, 4'd3, 16'h3000));
    run_mul(4'd7, mk(T_NOP, 4'd0, 4'd0, 16'h0000));
    chk("b2b_trig_cnt", trig_cnt, 2);
    chk("b2b_rel_cnt", rel_cnt, 2);
    tick();
    chk("b2b_nop_opcode", opcode, T_NOP);
    chk("b2b_nop_rw", regWrite, 0);
    chk("b2b_nop_valid", decValid, 1);

    // Reset in the middle of a sequence.
    instrIn = mk(T_MUL, 4'd3, 4'd2, 16'h3000);
    tick();
    chk("rm_trig", mul_trigger, 1);
    repeat (5) tick();
    chk("rm_busy", uopValid, 1);
    rst = 1'b1;
    exeOverride = 1'b1;
    #1;
    chk("rm_norel", mul_release, 0);
    chk("rm_notrig", mul_trigger, 0);
    tick();
    chk("rm_uopv", uopValid, 0);
    chk("rm_valid", decValid, 0);
    chk("rm_opcode", opcode, 0);
    chk("rm_rw", regWrite, 0);
    chk("rm_step", uopStep, 0);
    rst = 1'b0;
    exeOverride = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
